// File: rtl/qspi_sram_arbiter.sv
// qspi_sram_arbiter
//   Sequences the QSPI shifter and shares it between two requesters
//   (port 0 = data, port 1 = fetch). After reset it issues the
//   enter-quad-mode transaction once. It then serves word read and write
//   requests with round-robin arbitration, a forced chip-select gap between
//   transactions and a per-transaction timeout.
//
// Parameters
//   ADDR_W   SRAM byte-address width forwarded to the shifter
//   CS_GAP   idle cycles (sh_enable low) forced between transactions
//   TIMEOUT  max cycles in BUSY awaiting sh_done before abort (>= 2)
//
// Ports
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   o_init_done                 enter-quad-mode transaction has completed
//   o_busy                      arbiter is not idle
//   i_pN_req/we/addr/wdata      requester N command (held until o_pN_gnt)
//   o_pN_gnt                    request captured this cycle (combinational)
//   o_pN_done/err/rdata         completion pulse, timeout flag, read data
//   o_sh_enable/cmd/addr/wdata  shifter command (0=INIT, 1=READ, 2=WRITE)
//   i_sh_rdata, i_sh_done       shifter read data and completion pulse
module qspi_sram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int CS_GAP  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic              o_init_done,
    output logic              o_busy,
    input  logic              i_p0_req,
    input  logic              i_p0_we,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic [31:0]       i_p0_wdata,
    output logic              o_p0_gnt,
    output logic              o_p0_done,
    output logic              o_p0_err,
    output logic [31:0]       o_p0_rdata,
    input  logic              i_p1_req,
    input  logic              i_p1_we,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic [31:0]       i_p1_wdata,
    output logic              o_p1_gnt,
    output logic              o_p1_done,
    output logic              o_p1_err,
    output logic [31:0]       o_p1_rdata,
    output logic              o_sh_enable,
    output logic [1:0]        o_sh_cmd,
    output logic [ADDR_W-1:0] o_sh_addr,
    output logic [31:0]       o_sh_wdata,
    input  logic [31:0]       i_sh_rdata,
    input  logic              i_sh_done
);

    typedef enum logic [1:0] {S_INIT, S_GAP, S_IDLE, S_BUSY} state_t;

    localparam logic [1:0] CMD_INIT  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    // One counter serves as the BUSY timer and the GAP length counter.
    localparam int CNT_W = $clog2(TIMEOUT + CS_GAP + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    // The done cycle is the first GAP cycle; with CS_GAP=0 it is still spent
    // in GAP so the next grant lands one cycle after pN_done.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_gnt;
    logic               r_port;
    logic               r_init_done;
    logic               r_busy;
    logic               r_p0_done, r_p0_err, r_p1_done, r_p1_err;
    logic [31:0]        r_p0_rdata, r_p1_rdata;
    logic               r_sh_enable;
    logic [1:0]         r_sh_cmd;
    logic [ADDR_W-1:0]  r_sh_addr;
    logic [31:0]        r_sh_wdata;

    // NOTE: the grant is combinational from registered state so a requester
    // sees it in the same cycle it is captured; keep this path free of any
    // feedback from the grant itself.
    logic w_can_grant, w_pick1, w_p0_gnt, w_p1_gnt;
    assign w_can_grant = (r_state == S_IDLE) && r_init_done;
    // On a tie, serve the port that was not granted last.
    assign w_pick1     = i_p1_req && (!i_p0_req || !r_last_gnt);
    assign w_p1_gnt    = w_can_grant && w_pick1;
    assign w_p0_gnt    = w_can_grant && i_p0_req && !w_pick1;

    // NOTE: synchronous reset inside the clocked block, non-blocking
    // assignments only; every state register (no memories here) is reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_last_gnt  <= 1'b1;
            r_port      <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_p0_done   <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_done   <= 1'b0;
            r_p1_err    <= 1'b0;
            r_p1_rdata  <= '0;
            r_sh_enable <= 1'b0;
            r_sh_cmd    <= CMD_INIT;
            r_sh_addr   <= '0;
            r_sh_wdata  <= '0;
        end else begin
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_busy      <= 1'b1;
                    r_sh_enable <= 1'b1;
                    r_sh_cmd    <= CMD_INIT;
                    if (i_sh_done) begin
                        r_init_done <= 1'b1;
                        r_sh_enable <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_p0_gnt || w_p1_gnt) begin
                        r_port      <= w_p1_gnt;
                        r_last_gnt  <= w_p1_gnt;
                        r_sh_addr   <= w_p1_gnt ? i_p1_addr  : i_p0_addr;
                        r_sh_wdata  <= w_p1_gnt ? i_p1_wdata : i_p0_wdata;
                        r_sh_cmd    <= (w_p1_gnt ? i_p1_we : i_p0_we) ? CMD_WRITE : CMD_READ;
                        r_sh_enable <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_sh_done || r_cnt == TMO_LAST) begin
                        // sh_done takes priority over a simultaneous timeout.
                        if (r_port) begin
                            r_p1_done <= 1'b1;
                            r_p1_err  <= !i_sh_done;
                            if (!i_sh_done)
                                r_p1_rdata <= '0;
                            else if (r_sh_cmd == CMD_READ)
                                r_p1_rdata <= i_sh_rdata;
                        end else begin
                            r_p0_done <= 1'b1;
                            r_p0_err  <= !i_sh_done;
                            if (!i_sh_done)
                                r_p0_rdata <= '0;
                            else if (r_sh_cmd == CMD_READ)
                                r_p0_rdata <= i_sh_rdata;
                        end
                        r_sh_enable <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign o_init_done = r_init_done;
    assign o_busy      = r_busy;
    assign o_p0_gnt    = w_p0_gnt;
    assign o_p1_gnt    = w_p1_gnt;
    assign o_p0_done   = r_p0_done;
    assign o_p0_err    = r_p0_err;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_done   = r_p1_done;
    assign o_p1_err    = r_p1_err;
    assign o_p1_rdata  = r_p1_rdata;
    assign o_sh_enable = r_sh_enable;
    assign o_sh_cmd    = r_sh_cmd;
    assign o_sh_addr   = r_sh_addr;
    assign o_sh_wdata  = r_sh_wdata;

endmodule
